// File: rtl/sync_fifo_param_if.sv
// Handshake and status bundle between a producer/consumer and sync_fifo_param.
// The count width tracks DEPTH so that both sides agree on it.
interface sync_fifo_param_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 8
);
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic             wr;
    logic [WIDTH-1:0] din;
    logic             rd;
    logic             clr_err;
    logic [WIDTH-1:0] dout;
    logic             rd_valid;
    logic             empty;
    logic             full;
    logic             almost_empty;
    logic             almost_full;
    logic [CW-1:0]    count;
    logic             overflow;
    logic             underflow;

    modport master (
        output wr, din, rd, clr_err,
        input  dout, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );

    modport slave (
        input  wr, din, rd, clr_err,
        output dout, rd_valid, empty, full, almost_empty, almost_full,
               count, overflow, underflow
    );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with occupancy count, almost thresholds,
// registered read data with valid strobe and sticky overflow/underflow flags.
module sync_fifo_param #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned AF_LEVEL = DEPTH - 2,
    parameter int unsigned AE_LEVEL = 1
) (
    input logic              clk,
    input logic              rst_n,
    sync_fifo_param_if.slave bus
);
    localparam int unsigned   CW       = $clog2(DEPTH + 1);
    localparam int unsigned   PW       = $clog2(DEPTH);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wp;
    logic [PW-1:0]    rp;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] dout_q;
    logic             rd_valid_q;
    logic             overflow_q;
    logic             underflow_q;
    logic             rd_ok;
    logic             wr_ok;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST_PTR) ? '0 : p + PW'(1);
    endfunction

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    always_comb begin
        rd_ok = bus.rd && (cnt != '0);
        wr_ok = bus.wr && ((cnt != FULL_CNT) || rd_ok);
    end

    always_ff @(posedge clk) begin
        if (rst_n && wr_ok) begin
            mem[wp] <= bus.din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wp          <= '0;
            rp          <= '0;
            cnt         <= '0;
            dout_q      <= '0;
            rd_valid_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_ok) begin
                wp <= ptr_next(wp);
            end
            if (rd_ok) begin
                dout_q <= mem[rp];
                rp     <= ptr_next(rp);
            end
            rd_valid_q <= rd_ok;
            if (wr_ok && !rd_ok) begin
                cnt <= cnt + CW'(1);
            end else if (rd_ok && !wr_ok) begin
                cnt <= cnt - CW'(1);
            end
            // A new error outranks a coincident clear.
            overflow_q  <= (overflow_q && !bus.clr_err) || (bus.wr && !wr_ok);
            underflow_q <= (underflow_q && !bus.clr_err) || (bus.rd && !rd_ok);
        end
    end

    assign bus.dout         = dout_q;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.count        = cnt;
    assign bus.empty        = (cnt == '0);
    assign bus.full         = (cnt == FULL_CNT);
    assign bus.almost_empty = (cnt <= CW'(AE_LEVEL));
    assign bus.almost_full  = (cnt >= CW'(AF_LEVEL));
    assign bus.overflow     = overflow_q;
    assign bus.underflow    = underflow_q;
endmodule

// File: tb/tb_sync_fifo_param.sv
// Bench for sync_fifo_param: directed vector table on an 8-deep instance,
// then randomized traffic on 5- and 16-deep instances against a queue model.
module tb_sync_fifo_param;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    sync_fifo_param_if #(.WIDTH(8), .DEPTH(8))  b0 ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(5))  b1 ();
    sync_fifo_param_if #(.WIDTH(8), .DEPTH(16)) b2 ();

    sync_fifo_param #(.WIDTH(8), .DEPTH(8), .AF_LEVEL(6), .AE_LEVEL(1))
        u0 (.clk(clk), .rst_n(rst_n), .bus(b0.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(5), .AF_LEVEL(3), .AE_LEVEL(2))
        u1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
    sync_fifo_param #(.WIDTH(8), .DEPTH(16), .AF_LEVEL(16), .AE_LEVEL(0))
        u2 (.clk(clk), .rst_n(rst_n), .bus(b2.slave));

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic       rstn, wr, rd, clr;
        logic [7:0] din;
        int         cnt;
        logic [7:0] dout;
        logic       rdv, ov, un;
    } vec_t;
    vec_t vecs[$];

    // Reference model state: contents as a plain queue, oldest at the front.
    logic [7:0] mq[$];
    logic [7:0] m_dout;
    logic       m_rdv, m_ov, m_un;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    task automatic set_in(input int k, input logic r, w, rdi, c, input logic [7:0] d);
        rst_n = r;
        case (k)
            0: begin b0.wr = w; b0.rd = rdi; b0.clr_err = c; b0.din = d; end
            1: begin b1.wr = w; b1.rd = rdi; b1.clr_err = c; b1.din = d; end
            default: begin b2.wr = w; b2.rd = rdi; b2.clr_err = c; b2.din = d; end
        endcase
    endtask

    task automatic cmp_out(input int k, input string tag, input int depth, af, ae,
                           input int cnt, input logic [7:0] dout,
                           input logic rdv, ov, un);
        int o_cnt, o_dout, o_rdv, o_e, o_f, o_ae, o_af, o_ov, o_un;
        case (k)
            0: begin o_cnt = int'(b0.count); o_dout = int'(b0.dout); o_rdv = int'(b0.rd_valid);
                     o_e = int'(b0.empty); o_f = int'(b0.full); o_ae = int'(b0.almost_empty);
                     o_af = int'(b0.almost_full); o_ov = int'(b0.overflow); o_un = int'(b0.underflow); end
            1: begin o_cnt = int'(b1.count); o_dout = int'(b1.dout); o_rdv = int'(b1.rd_valid);
                     o_e = int'(b1.empty); o_f = int'(b1.full); o_ae = int'(b1.almost_empty);
                     o_af = int'(b1.almost_full); o_ov = int'(b1.overflow); o_un = int'(b1.underflow); end
            default: begin o_cnt = int'(b2.count); o_dout = int'(b2.dout); o_rdv = int'(b2.rd_valid);
                     o_e = int'(b2.empty); o_f = int'(b2.full); o_ae = int'(b2.almost_empty);
                     o_af = int'(b2.almost_full); o_ov = int'(b2.overflow); o_un = int'(b2.underflow); end
        endcase
        check({tag, ".count"}, o_cnt, cnt);
        check({tag, ".dout"}, o_dout, int'(dout));
        check({tag, ".rd_valid"}, o_rdv, int'(rdv));
        check({tag, ".empty"}, o_e, int'(cnt == 0));
        check({tag, ".full"}, o_f, int'(cnt == depth));
        check({tag, ".almost_empty"}, o_ae, int'(cnt <= ae));
        check({tag, ".almost_full"}, o_af, int'(cnt >= af));
        check({tag, ".overflow"}, o_ov, int'(ov));
        check({tag, ".underflow"}, o_un, int'(un));
    endtask

    task automatic add(input logic r, w, rdi, c, input logic [7:0] d, input int cnt,
                       input logic [7:0] dout, input logic rdv, ov, un);
        vec_t v;
        v.rstn = r; v.wr = w; v.rd = rdi; v.clr = c; v.din = d;
        v.cnt = cnt; v.dout = dout; v.rdv = rdv; v.ov = ov; v.un = un;
        vecs.push_back(v);
    endtask

    // Behavioural rules: reads pop the oldest entry, writes need a free slot
    // (or one being freed this cycle), rejected requests raise sticky errors.
    task automatic model_step(input int depth, input logic r, w, rdi, c, input logic [7:0] d);
        bit can_rd, can_wr;
        if (!r) begin
            mq.delete(); m_dout = 8'h00; m_rdv = 1'b0; m_ov = 1'b0; m_un = 1'b0;
            return;
        end
        can_rd = rdi && (mq.size() > 0);
        can_wr = w && ((mq.size() < depth) || can_rd);
        m_rdv = can_rd;
        if (can_rd) m_dout = mq.pop_front();
        if (can_wr) mq.push_back(d);
        m_ov = (m_ov && !c) || (w && !can_wr);
        m_un = (m_un && !c) || (rdi && !can_rd);
    endtask

    task automatic stress(input int k, input int depth, af, ae, input int cycles);
        logic r, w, rdi, c;
        logic [7:0] d;
        int wp_pct, rd_pct;
        for (int n = 0; n < cycles; n++) begin
            // Alternate fill-biased and drain-biased phases to reach both ends.
            wp_pct = ((n / 150) % 2 == 0) ? 70 : 35;
            rd_pct = ((n / 150) % 2 == 0) ? 35 : 70;
            r   = (n < 2) ? 1'b0 : ($urandom_range(0, 199) != 0);
            w   = ($urandom_range(0, 99) < wp_pct);
            rdi = ($urandom_range(0, 99) < rd_pct);
            c   = ($urandom_range(0, 99) < 5);
            d   = 8'($urandom);
            set_in(k, r, w, rdi, c, d);
            model_step(depth, r, w, rdi, c, d);
            @(posedge clk);
            #1;
            cmp_out(k, $sformatf("rnd_d%0d[%0d]", depth, n), depth, af, ae,
                    mq.size(), m_dout, m_rdv, m_ov, m_un);
        end
        set_in(k, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        set_in(0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        set_in(1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        set_in(2, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

        // Reset held with requests active
        add(0, 1, 1, 0, 8'h77, 0, 8'h00, 0, 0, 0);
        add(0, 1, 1, 0, 8'h77, 0, 8'h00, 0, 0, 0);
        // Order and read latency
        add(1, 1, 0, 0, 8'h11, 1, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h22, 2, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h33, 3, 8'h00, 0, 0, 0);
        add(1, 1, 0, 0, 8'h44, 4, 8'h00, 0, 0, 0);
        add(1, 0, 1, 0, 8'h00, 3, 8'h11, 1, 0, 0);
        add(1, 0, 1, 0, 8'h00, 2, 8'h22, 1, 0, 0);
        add(1, 0, 1, 0, 8'h00, 1, 8'h33, 1, 0, 0);
        add(1, 0, 1, 0, 8'h00, 0, 8'h44, 1, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 8'h44, 0, 0, 0);
        // Underflow, clear, simultaneous wr/rd on empty
        add(1, 0, 1, 0, 8'h00, 0, 8'h44, 0, 0, 1);
        add(1, 0, 0, 1, 8'h00, 0, 8'h44, 0, 0, 0);
        add(1, 1, 1, 0, 8'h66, 1, 8'h44, 0, 0, 1);
        add(1, 0, 0, 1, 8'h00, 1, 8'h44, 0, 0, 0);
        add(1, 0, 1, 0, 8'h00, 0, 8'h66, 1, 0, 0);
        // Fill, overflow, full-boundary wr+rd, drain
        for (int i = 1; i <= 8; i++) add(1, 1, 0, 0, 8'(i), i, 8'h66, 0, 0, 0);
        add(1, 1, 0, 0, 8'hAA, 8, 8'h66, 0, 1, 0);
        add(1, 1, 1, 0, 8'h5A, 8, 8'h01, 1, 1, 0);
        add(1, 0, 0, 1, 8'h00, 8, 8'h01, 0, 0, 0);
        for (int i = 2; i <= 8; i++) add(1, 0, 1, 0, 8'h00, 9 - i, 8'(i), 1, 0, 0);
        add(1, 0, 1, 0, 8'h00, 0, 8'h5A, 1, 0, 0);
        // Mid-stream reset at count 5 with a read result and error pending
        add(1, 0, 1, 0, 8'h00, 0, 8'h5A, 0, 0, 1);
        for (int i = 1; i <= 5; i++) add(1, 1, 0, 0, 8'(8'h90 + i), i, 8'h5A, 0, 0, 1);
        add(1, 1, 1, 0, 8'h96, 5, 8'h91, 1, 0, 1);
        add(0, 1, 1, 0, 8'h77, 0, 8'h00, 0, 0, 0);
        add(1, 0, 0, 0, 8'h00, 0, 8'h00, 0, 0, 0);

        foreach (vecs[i]) begin
            set_in(0, vecs[i].rstn, vecs[i].wr, vecs[i].rd, vecs[i].clr, vecs[i].din);
            @(posedge clk);
            #1;
            cmp_out(0, $sformatf("vec[%0d]", i), 8, 6, 1,
                    vecs[i].cnt, vecs[i].dout, vecs[i].rdv, vecs[i].ov, vecs[i].un);
        end

        // Streaming wr+rd every cycle: pointers wrap several times, no bubbles
        set_in(0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h40);
        @(posedge clk);
        #1;
        cmp_out(0, "stream_prime", 8, 6, 1, 1, 8'h00, 0, 0, 0);
        for (int i = 1; i <= 30; i++) begin
            set_in(0, 1'b1, 1'b1, 1'b1, 1'b0, 8'(8'h40 + i));
            @(posedge clk);
            #1;
            cmp_out(0, $sformatf("stream[%0d]", i), 8, 6, 1, 1, 8'(8'h40 + i - 1), 1, 0, 0);
        end
        set_in(0, 1'b1, 1'b0, 1'b1, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        cmp_out(0, "stream_tail", 8, 6, 1, 0, 8'h5E, 1, 0, 0);
        set_in(0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);

        stress(1, 5, 3, 2, 2000);
        stress(2, 16, 16, 0, 2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
